// File: rtl/connect_sched_pkg.sv
// Shared definitions for the fully-connected stage sequencer.
package connect_sched_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLoad  = 3'd2,
    StIssue = 3'd3,
    StWait  = 3'd4,
    StPush  = 3'd5,
    StFin   = 3'd6
  } state_e;

  localparam int unsigned BURST_LEN = 9;
  localparam int unsigned CM_VEC_W  = 216;

endpackage

// File: rtl/connect_argmax.sv
// Running arg-max register; ties keep the earlier (lower) index.
module connect_argmax #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned VAL_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             upd,
  input  logic             first,
  input  logic [VAL_W-1:0] value,
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] best_idx
);

  logic [VAL_W-1:0] best_q;
  logic [IDX_W-1:0] best_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q     <= '0;
      best_idx_q <= '0;
    end else if (clr) begin
      best_q     <= '0;
      best_idx_q <= '0;
    end else if (upd && (first || value > best_q)) begin
      best_q     <= value;
      best_idx_q <= idx;
    end
  end

  assign best_idx = best_idx_q;

endmodule

// File: rtl/counter_utility.sv
// Free-running modulo counter with synchronous clear and count enable.
module counter_utility #(
  parameter int unsigned CNT_WIDTH = 4,
  parameter int unsigned CNT_MAX   = 9
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == CNT_WIDTH'(CNT_MAX - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/connect_sched.sv
// Fully-connected stage sequencer: one 9-cycle dot-product burst per weight set,
// results streamed out over valid/ready with a running arg-max.
module connect_sched
  import connect_sched_pkg::*;
#(
  parameter int unsigned N_OUT   = 10,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned VEC_W   = CM_VEC_W,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VEC_W-1:0] feat_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wt_rd_en,
  output logic [IDX_W-1:0] wt_addr,
  input  logic [VEC_W-1:0] wt_rdata,
  output logic             cm_in_vld,
  output logic [VEC_W-1:0] cm_pool_lin,
  output logic [VEC_W-1:0] cm_weight_lin,
  input  logic [7:0]       cm_ans_reg,
  input  logic             cm_out_vld,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [IDX_W-1:0] res_idx,
  output logic [7:0]       res_data,
  output logic [IDX_W-1:0] cls_idx
);

  localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [VEC_W-1:0] pool_q, weight_q;
  logic [7:0]       res_data_q;
  logic [IDX_W-1:0] res_idx_q;
  logic             err_q;
  logic [TMO_W-1:0] tmo_q;
  logic [3:0]       burst_cnt;
  logic             accept, last_idx, tmo_hit, xfer;

  assign accept   = (state_q == StIdle) && start;
  assign last_idx = (idx_q == IDX_W'(N_OUT - 1));
  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT - 1));
  assign xfer     = (state_q == StPush) && res_rdy;

  counter_utility #(
    .CNT_WIDTH(4),
    .CNT_MAX  (BURST_LEN)
  ) u_burst (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == StLoad),
    .en   (state_q == StIssue),
    .cnt  (burst_cnt)
  );

  connect_argmax #(
    .IDX_W(IDX_W),
    .VAL_W(8)
  ) u_argmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (accept),
    .upd     (xfer),
    .first   (idx_q == '0),
    .value   (res_data_q),
    .idx     (idx_q),
    .best_idx(cls_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StFetch;
      StFetch: state_d = StLoad;
      StLoad:  state_d = StIssue;
      StIssue: if (burst_cnt == 4'(BURST_LEN - 1)) state_d = StWait;
      StWait: begin
        if (cm_out_vld) state_d = StPush;
        else if (tmo_hit) state_d = StFin;
      end
      StPush:  if (res_rdy) state_d = last_idx ? StFin : StFetch;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      pool_q     <= '0;
      weight_q   <= '0;
      res_data_q <= '0;
      res_idx_q  <= '0;
      err_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      if (accept) begin
        pool_q <= feat_in;
        idx_q  <= '0;
      end else if (xfer && !last_idx) begin
        idx_q <= idx_q + 1'b1;
      end
      if (state_q == StLoad) begin
        weight_q <= wt_rdata;
        tmo_q    <= '0;
      end else if (state_q == StWait) begin
        tmo_q <= tmo_q + 1'b1;
      end
      if (state_q == StWait && cm_out_vld) begin
        res_data_q <= cm_ans_reg;
        res_idx_q  <= idx_q;
      end
      // A result arriving outside WAIT is dropped but flagged.
      if (accept) begin
        err_q <= 1'b0;
      end else if ((state_q != StWait && cm_out_vld) ||
                   (state_q == StWait && !cm_out_vld && tmo_hit)) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    busy          = (state_q != StIdle);
    done          = (state_q == StFin);
    wt_rd_en      = (state_q == StFetch);
    wt_addr       = idx_q;
    cm_in_vld     = (state_q == StIssue);
    cm_pool_lin   = pool_q;
    cm_weight_lin = weight_q;
    res_vld       = (state_q == StPush);
    res_idx       = res_idx_q;
    res_data      = res_data_q;
    err           = err_q;
  end

endmodule

// File: tb/tb_connect_sched.sv
// Directed bench for connect_sched with a behavioural weight memory and datapath.
module tb_connect_sched;

  localparam int unsigned N_OUT   = 10;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned VEC_W   = 216;
  localparam int unsigned TIMEOUT = 32;
  localparam int          LAT     = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [VEC_W-1:0] feat_in = '0;
  logic             busy, done, err, wt_rd_en, cm_in_vld, res_vld;
  logic [IDX_W-1:0] wt_addr, res_idx, cls_idx;
  logic [VEC_W-1:0] wt_rdata = '0;
  logic [VEC_W-1:0] cm_pool_lin, cm_weight_lin;
  logic [7:0]       cm_ans_reg = '0;
  logic             cm_out_vld = 1'b0;
  logic             res_rdy = 1'b1;
  logic [7:0]       res_data;

  int checks = 0;
  int errors = 0;

  connect_sched #(
    .N_OUT  (N_OUT),
    .IDX_W  (IDX_W),
    .VEC_W  (VEC_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .feat_in      (feat_in),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .wt_rd_en     (wt_rd_en),
    .wt_addr      (wt_addr),
    .wt_rdata     (wt_rdata),
    .cm_in_vld    (cm_in_vld),
    .cm_pool_lin  (cm_pool_lin),
    .cm_weight_lin(cm_weight_lin),
    .cm_ans_reg   (cm_ans_reg),
    .cm_out_vld   (cm_out_vld),
    .res_vld      (res_vld),
    .res_rdy      (res_rdy),
    .res_idx      (res_idx),
    .res_data     (res_data),
    .cls_idx      (cls_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [VEC_W-1:0] wgen(input logic [IDX_W-1:0] a);
    logic [7:0] b;
    b = 8'(a) * 8'd7 + 8'd1;
    return {27{b}};
  endfunction

  function automatic logic [VEC_W-1:0] fgen(input logic [7:0] s);
    return {27{s}};
  endfunction

  // Weight memory (one-cycle read latency) and datapath (result LAT cycles after burst).
  int unsigned      res_tab[N_OUT];
  int               drop_idx = -1;
  logic             inject = 1'b0;
  logic [IDX_W-1:0] cur_idx = '0;
  logic [IDX_W-1:0] rd_addr = '0;
  bit               rd_pend = 0;
  bit               armed = 0;
  int               wcnt = 0;

  always @(negedge clk) begin
    wt_rdata = rd_pend ? wgen(rd_addr) : {VEC_W{1'b1}};
    rd_pend  = wt_rd_en;
    rd_addr  = wt_addr;
    cm_out_vld = 1'b0;
    if (!busy) armed = 0;
    if (wt_rd_en) cur_idx = wt_addr;
    if (cm_in_vld) begin
      armed = 1;
      wcnt  = 0;
    end else if (armed) begin
      wcnt++;
      if (wcnt == LAT) begin
        armed = 0;
        if (int'(cur_idx) != drop_idx) begin
          cm_out_vld = 1'b1;
          cm_ans_reg = 8'(res_tab[int'(cur_idx)]);
        end
      end
    end
    if (inject) begin
      cm_out_vld = 1'b1;
      cm_ans_reg = 8'hEE;
    end
  end

  // Observers.
  int         cycle = 0;
  int         t_done = 0;
  int         nxfer = 0, vld_total = 0, run_bad = 0, done_cnt = 0, run = 0;
  logic [7:0] xd[$];
  logic [IDX_W-1:0] xi[$];

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (cm_in_vld) begin
      vld_total++;
      run++;
    end else if (run != 0) begin
      if (run != 9) run_bad++;
      run = 0;
    end
    if (done) begin
      done_cnt++;
      t_done = cycle;
    end
    if (res_vld && res_rdy) begin
      xd.push_back(res_data);
      xi.push_back(res_idx);
      nxfer++;
    end
  end

  int t_start = 0, xbase = 0, vbase = 0, rbase = 0, dbase = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [VEC_W-1:0] f);
    @(posedge clk);
    #1;
    start   = 1'b1;
    feat_in = f;
    t_start = cycle;
    xbase   = nxfer;
    vbase   = vld_total;
    rbase   = run_bad;
    dbase   = done_cnt;
    @(posedge clk);
    #1;
    start   = 1'b0;
    feat_in = ~f;
  endtask

  // mode 0: issuing idx a; 1: fetching idx a; 2: res_vld; 3: cm_in_vld low
  task automatic wait_for(input string tag, input int mode, input int a);
    int n = 0;
    bit hit = 0;
    while (!hit && n < 1000) begin
      @(negedge clk);
      n++;
      case (mode)
        0:       hit = cm_in_vld && (int'(wt_addr) == a);
        1:       hit = wt_rd_en && (int'(wt_addr) == a);
        2:       hit = res_vld;
        default: hit = !cm_in_vld;
      endcase
    end
    check({tag, " reached"}, 256'(hit), 256'(1));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == dbase && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done seen"}, 256'(done_cnt != dbase), 256'(1));
    repeat (3) @(negedge clk);
    check({tag, " done single"}, 256'(done_cnt - dbase), 256'(1));
  endtask

  task automatic check_full(input string tag, input logic [IDX_W-1:0] cls);
    int bad = 0;
    check({tag, " nxfer"}, 256'(nxfer - xbase), 256'(N_OUT));
    for (int i = 0; i < int'(N_OUT); i++) begin
      if (xbase + i < nxfer) begin
        if (xd[xbase + i] !== 8'(res_tab[i]) || xi[xbase + i] !== IDX_W'(i)) bad++;
      end
    end
    check({tag, " res stream"}, 256'(bad), 256'(0));
    check({tag, " cls_idx"}, 256'(cls_idx), 256'(cls));
    check({tag, " vld total"}, 256'(vld_total - vbase), 256'(90));
    check({tag, " burst runs"}, 256'(run_bad - rbase), 256'(0));
  endtask

  initial begin
    int k;
    int sbad;
    for (int i = 0; i < int'(N_OUT); i++) res_tab[i] = 10 * i;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", 256'(busy), 256'(0));
    check("rst err", 256'(err), 256'(0));
    check("rst res_vld", 256'(res_vld), 256'(0));
    check("rst cls_idx", 256'(cls_idx), 256'(0));
    check("rst pool", 256'(cm_pool_lin), 256'(0));
    rst_n = 1'b1;

    // Frame 1: results 10*idx, full-rate handshake.
    start_frame(fgen(8'hA5));
    @(negedge clk);
    check("t1 fetch rd_en", 256'(wt_rd_en), 256'(1));
    check("t1 fetch addr", 256'(wt_addr), 256'(0));
    check("t1 pool latched", 256'(cm_pool_lin), 256'(fgen(8'hA5)));
    check("t1 busy", 256'(busy), 256'(1));
    @(negedge clk);
    check("t1 load rd_en", 256'(wt_rd_en), 256'(0));
    check("t1 load in_vld", 256'(cm_in_vld), 256'(0));
    @(negedge clk);
    check("t1 issue in_vld", 256'(cm_in_vld), 256'(1));
    check("t1 issue weight", 256'(cm_weight_lin), 256'(wgen(4'd0)));
    wait_done("t1");
    check_full("t1", 4'd9);
    check("t1 frame len", 256'(t_done - t_start), 256'(151));
    check("t1 err", 256'(err), 256'(0));

    // Frame 2: ties at the maximum keep the lower index.
    res_tab = '{5, 200, 200, 7, 100, 9, 199, 0, 3, 150};
    start_frame(fgen(8'h3C));
    wait_done("t2");
    check_full("t2", 4'd1);

    // Frame 3: back-pressure on the result of idx 3.
    for (int i = 0; i < int'(N_OUT); i++) res_tab[i] = 10 * i;
    start_frame(fgen(8'h11));
    wait_for("t3 fetch3", 1, 3);
    @(posedge clk);
    #1;
    res_rdy = 1'b0;
    wait_for("t3 push", 2, 0);
    sbad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i != 0) @(negedge clk);
      if (res_vld !== 1'b1 || res_data !== 8'd30 || res_idx !== 4'd3 ||
          cm_in_vld !== 1'b0 || wt_rd_en !== 1'b0) sbad++;
    end
    check("t3 stall stable", 256'(sbad), 256'(0));
    check("t3 no xfer in stall", 256'(nxfer - xbase), 256'(3));
    @(posedge clk);
    #1;
    res_rdy = 1'b1;
    wait_done("t3");
    check_full("t3", 4'd9);

    // Frame 4: datapath never answers for idx 4.
    res_tab = '{50, 80, 20, 80, 90, 99, 99, 99, 99, 99};
    drop_idx = 4;
    start_frame(fgen(8'h77));
    wait_for("t4 issue4", 0, 4);
    wait_for("t4 wait4", 3, 0);
    k = 1;
    while (err !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t4 err at timeout", 256'(k), 256'(TIMEOUT + 1));
    check("t4 done with err", 256'(done), 256'(1));
    repeat (3) @(negedge clk);
    check("t4 done single", 256'(done_cnt - dbase), 256'(1));
    check("t4 nxfer", 256'(nxfer - xbase), 256'(4));
    check("t4 cls_idx", 256'(cls_idx), 256'(1));
    check("t4 err sticky", 256'(err), 256'(1));
    check("t4 idle", 256'(busy), 256'(0));
    drop_idx = -1;

    // Frame 5: start clears err; start while busy and spurious result ignored.
    for (int i = 0; i < int'(N_OUT); i++) res_tab[i] = 10 * i;
    start_frame(fgen(8'h5A));
    @(negedge clk);
    check("t5 err cleared", 256'(err), 256'(0));
    wait_for("t5 issue0", 0, 0);
    @(posedge clk);
    #1;
    start   = 1'b1;
    feat_in = fgen(8'hC3);
    inject  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    inject = 1'b0;
    @(negedge clk);
    check("t5 spurious err", 256'(err), 256'(1));
    check("t5 pool held", 256'(cm_pool_lin), 256'(fgen(8'h5A)));
    wait_done("t5");
    check_full("t5", 4'd9);
    check("t5 frame len", 256'(t_done - t_start), 256'(151));

    // Frame 6: reset during the burst of idx 6, then a clean frame.
    start_frame(fgen(8'h99));
    wait_for("t6 issue0", 0, 0);
    @(posedge clk);
    #1;
    inject = 1'b1;
    @(posedge clk);
    #1;
    inject = 1'b0;
    wait_for("t6 issue6", 0, 6);
    repeat (2) @(negedge clk);
    check("t6 err pre-reset", 256'(err), 256'(1));
    rst_n = 1'b0;
    #1;
    check("t6 rst busy", 256'(busy), 256'(0));
    check("t6 rst err", 256'(err), 256'(0));
    check("t6 rst in_vld", 256'(cm_in_vld), 256'(0));
    check("t6 rst operands", 256'({cm_pool_lin, cm_weight_lin} != '0), 256'(0));
    check("t6 rst res", 256'({res_vld, res_idx, res_data, wt_rd_en, wt_addr}), 256'(0));
    check("t6 rst cls_idx", 256'(cls_idx), 256'(0));
    dbase = done_cnt;
    repeat (5) @(negedge clk);
    check("t6 no done", 256'(done_cnt - dbase), 256'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start_frame(fgen(8'h42));
    wait_done("t6");
    check_full("t6", 4'd9);
    check("t6 frame len", 256'(t_done - t_start), 256'(151));
    check("t6 err", 256'(err), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
